// File: rtl/axis_reg_pcie_rxs_if.sv
// rtl/axis_reg_pcie_rxs_if.sv - PCIe RX stream bundle (valid/data/last/user) for axis_reg_pcie_rxs
interface axis_reg_pcie_rxs_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 32
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tvalid, tdata, tlast, tuser);
    modport slave  (input  tvalid, tdata, tlast, tuser);
endinterface

// File: rtl/axis_reg_pcie_rxs.sv
// rtl/axis_reg_pcie_rxs.sv - multi-stage skid-register pipeline for the PCIe RX stream with monitor and counters
module axis_reg_pcie_rxs #(
    parameter int NUM_PIPELINES  = 1,
    parameter bit TREADY_RST_VAL = 1'b0,
    parameter int CNT_W          = 16,
    parameter int DATA_W         = 256,
    parameter int USER_W         = 32,
    localparam int OCC_W         = $clog2(2 * NUM_PIPELINES + 1)
) (
    input  logic               s_if_clk,
    input  logic               s_if_rst_n,
    axis_reg_pcie_rxs_if.slave s_if,
    output logic               s_if_tready,
    output logic               m_if_clk,
    output logic               m_if_rst_n,
    axis_reg_pcie_rxs_if.master m_if,
    input  logic               m_if_tready,
    output logic               prot_err,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic [OCC_W-1:0]   occupancy
);
    localparam int NP = NUM_PIPELINES;
    localparam int PW = DATA_W + 1 + USER_W;

    if (NUM_PIPELINES < 1 || NUM_PIPELINES > 8) begin : g_bad_param
        $error("axis_reg_pcie_rxs: NUM_PIPELINES=%0d outside 1..8", NUM_PIPELINES);
    end

    logic [NP-1:0] main_valid;
    logic [NP-1:0] ready_reg;
    logic [PW-1:0] main_data [NP];
    logic [PW-1:0] s_payload;

    assign s_payload = {s_if.tuser, s_if.tlast, s_if.tdata};

    for (genvar k = 0; k < NP; k++) begin : g_stage
        logic          in_valid, out_ready, acc, leave;
        logic [PW-1:0] in_data;
        logic          mv, sv, rr, mv_nxt, sv_nxt;
        logic          ld_main_in, ld_main_skid, ld_skid;
        logic [PW-1:0] md, sd;

        if (k == 0) begin : g_head
            assign in_valid = s_if.tvalid;
            assign in_data  = s_payload;
        end else begin : g_link
            assign in_valid = main_valid[k-1];
            assign in_data  = main_data[k-1];
        end

        if (k == NP - 1) begin : g_tail
            assign out_ready = m_if_tready;
        end else begin : g_mid
            assign out_ready = ready_reg[k+1];
        end

        assign acc   = in_valid && rr;
        assign leave = mv && out_ready;

        // rr is !skid, so an accept never coincides with a full skid
        always_comb begin
            mv_nxt       = mv;
            sv_nxt       = sv;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
            if (!mv || leave) begin
                if (sv) begin
                    ld_main_skid = 1'b1;
                    mv_nxt       = 1'b1;
                    sv_nxt       = 1'b0;
                end else if (acc) begin
                    ld_main_in = 1'b1;
                    mv_nxt     = 1'b1;
                end else begin
                    mv_nxt = 1'b0;
                end
            end else if (acc) begin
                ld_skid = 1'b1;
                sv_nxt  = 1'b1;
            end
        end

        always_ff @(posedge s_if_clk or negedge s_if_rst_n) begin
            if (!s_if_rst_n) begin
                mv <= 1'b0;
                sv <= 1'b0;
                rr <= TREADY_RST_VAL;
            end else begin
                mv <= mv_nxt;
                sv <= sv_nxt;
                rr <= !sv_nxt;
            end
        end

        always_ff @(posedge s_if_clk) begin
            if (ld_main_in) begin
                md <= in_data;
            end else if (ld_main_skid) begin
                md <= sd;
            end
            if (ld_skid) begin
                sd <= in_data;
            end
        end

        assign main_valid[k] = mv;
        assign ready_reg[k]  = rr;
        assign main_data[k]  = md;
    end

    assign s_if_tready = ready_reg[0];
    assign m_if.tvalid = main_valid[NP-1];
    assign {m_if.tuser, m_if.tlast, m_if.tdata} = main_data[NP-1];
    assign m_if_clk   = s_if_clk;
    assign m_if_rst_n = s_if_rst_n;

    logic          in_acc, out_acc, hold_valid;
    logic [PW-1:0] held_payload;

    assign in_acc  = s_if.tvalid && s_if_tready;
    assign out_acc = main_valid[NP-1] && m_if_tready;

    always_ff @(posedge s_if_clk or negedge s_if_rst_n) begin
        if (!s_if_rst_n) begin
            occupancy  <= '0;
            pkt_cnt    <= '0;
            beat_cnt   <= '0;
            prot_err   <= 1'b0;
            hold_valid <= 1'b0;
        end else begin
            occupancy  <= occupancy + OCC_W'(in_acc) - OCC_W'(out_acc);
            beat_cnt   <= beat_cnt + CNT_W'(out_acc);
            pkt_cnt    <= pkt_cnt + CNT_W'(out_acc && m_if.tlast);
            hold_valid <= s_if.tvalid && !s_if_tready;
            // a stalled beat must reappear unchanged on the following cycle
            if (hold_valid && (!s_if.tvalid || s_payload != held_payload)) begin
                prot_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge s_if_clk) begin
        if (s_if.tvalid && !s_if_tready) begin
            held_payload <= s_payload;
        end
    end
endmodule

// File: tb/tb_axis_reg_pcie_rxs.sv
// tb/tb_axis_reg_pcie_rxs.sv - directed and scoreboard bench for axis_reg_pcie_rxs
module tb_axis_reg_pcie_rxs;
    localparam int DW = 16;
    localparam int UW = 4;
    localparam int CW = 16;
    localparam int PW = DW + 1 + UW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_beat_a = 0;
    int exp_pkt_a  = 0;

    axis_reg_pcie_rxs_if #(.DATA_W(DW), .USER_W(UW)) sa_if ();
    axis_reg_pcie_rxs_if #(.DATA_W(DW), .USER_W(UW)) ma_if ();
    axis_reg_pcie_rxs_if #(.DATA_W(DW), .USER_W(UW)) sb_if ();
    axis_reg_pcie_rxs_if #(.DATA_W(DW), .USER_W(UW)) mb_if ();

    logic          a_s_tready, a_m_tready, a_mclk, a_mrst_n, a_prot_err;
    logic [CW-1:0] a_pkt_cnt, a_beat_cnt;
    logic [2:0]    a_occ;
    logic          b_s_tready, b_m_tready, b_mclk, b_mrst_n, b_prot_err;
    logic [CW-1:0] b_pkt_cnt, b_beat_cnt;
    logic [2:0]    b_occ;

    logic          a_in_acc, a_out_acc;
    logic [PW-1:0] a_out_pay;
    logic [2:0]    a_occ_s;

    axis_reg_pcie_rxs #(.NUM_PIPELINES(2), .TREADY_RST_VAL(1'b1), .CNT_W(CW),
                        .DATA_W(DW), .USER_W(UW)) dut_a (
        .s_if_clk(clk), .s_if_rst_n(rst_n), .s_if(sa_if), .s_if_tready(a_s_tready),
        .m_if_clk(a_mclk), .m_if_rst_n(a_mrst_n), .m_if(ma_if), .m_if_tready(a_m_tready),
        .prot_err(a_prot_err), .pkt_cnt(a_pkt_cnt), .beat_cnt(a_beat_cnt), .occupancy(a_occ)
    );

    axis_reg_pcie_rxs #(.NUM_PIPELINES(3), .TREADY_RST_VAL(1'b0), .CNT_W(CW),
                        .DATA_W(DW), .USER_W(UW)) dut_b (
        .s_if_clk(clk), .s_if_rst_n(rst_n), .s_if(sb_if), .s_if_tready(b_s_tready),
        .m_if_clk(b_mclk), .m_if_rst_n(b_mrst_n), .m_if(mb_if), .m_if_tready(b_m_tready),
        .prot_err(b_prot_err), .pkt_cnt(b_pkt_cnt), .beat_cnt(b_beat_cnt), .occupancy(b_occ)
    );

    // called at a negedge; drives one cycle on dut_a and samples the handshake before the posedge
    task automatic step_a(input logic v, input logic [DW-1:0] d, input logic l,
                          input logic [UW-1:0] u, input logic rdy);
        sa_if.tvalid = v;
        sa_if.tdata  = d;
        sa_if.tlast  = l;
        sa_if.tuser  = u;
        a_m_tready   = rdy;
        #2;
        a_in_acc  = sa_if.tvalid && a_s_tready;
        a_out_acc = ma_if.tvalid && a_m_tready;
        a_out_pay = {ma_if.tuser, ma_if.tlast, ma_if.tdata};
        a_occ_s   = a_occ;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_s_tready !== 1'b1) begin errors++; $display("FAIL rst_tready_a: got %b want 1", a_s_tready); end
        checks++; if (ma_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid_a: got %b want 0", ma_if.tvalid); end
        checks++; if (b_s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready_b: got %b want 0", b_s_tready); end
        checks++;
        if (a_occ !== 3'd0 || a_pkt_cnt !== 16'd0 || a_beat_cnt !== 16'd0 || a_prot_err !== 1'b0) begin
            errors++; $display("FAIL rst_status_a: got occ=%0d pkt=%0d beat=%0d perr=%b want all 0",
                               a_occ, a_pkt_cnt, a_beat_cnt, a_prot_err);
        end
        rst_n = 1'b1;
        step_a(1'b1, 16'h00A5, 1'b1, 4'h3, 1'b1);
        checks++; if (a_in_acc !== 1'b1) begin errors++; $display("FAIL first_accept: got %b want 1", a_in_acc); end
        checks++; if (ma_if.tvalid !== 1'b0) begin errors++; $display("FAIL early_tvalid: got %b want 0", ma_if.tvalid); end
        checks++; if (b_s_tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready_b: got %b want 1", b_s_tready); end
        step_a(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1);
        checks++;
        if (ma_if.tvalid !== 1'b1 || ma_if.tdata !== 16'h00A5 || ma_if.tlast !== 1'b1 || ma_if.tuser !== 4'h3) begin
            errors++; $display("FAIL latency_beat: got v=%b d=%h l=%b u=%h want v=1 d=00a5 l=1 u=3",
                               ma_if.tvalid, ma_if.tdata, ma_if.tlast, ma_if.tuser);
        end
        step_a(1'b0, 16'h0000, 1'b0, 4'h0, 1'b1);
        exp_beat_a = 1;
        exp_pkt_a  = 1;
        checks++;
        if (a_pkt_cnt !== 16'd1 || a_beat_cnt !== 16'd1 || ma_if.tvalid !== 1'b0) begin
            errors++; $display("FAIL first_counts: got pkt=%0d beat=%0d v=%b want 1 1 0", a_pkt_cnt, a_beat_cnt, ma_if.tvalid);
        end
    endtask

    task automatic test_streaming();
        int sent, recv, first_in, first_out, last_out, occ_max;
        sent = 0; recv = 0; first_in = -1; first_out = -1; last_out = -1; occ_max = 0;
        for (int cyc = 0; cyc < 200 && recv < 100; cyc++) begin
            sb_if.tvalid = (sent < 100);
            sb_if.tdata  = DW'(sent);
            sb_if.tlast  = (sent % 10 == 9);
            sb_if.tuser  = UW'(sent);
            b_m_tready   = 1'b1;
            #2;
            if (int'(b_occ) > occ_max) occ_max = int'(b_occ);
            if (mb_if.tvalid) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                checks++;
                if (mb_if.tdata !== DW'(recv) || mb_if.tlast !== (recv % 10 == 9)) begin
                    errors++; $display("FAIL stream_beat%0d: got d=%h l=%b want d=%h l=%b",
                                       recv, mb_if.tdata, mb_if.tlast, DW'(recv), (recv % 10 == 9));
                end
                recv++;
            end
            if (sb_if.tvalid && b_s_tready) begin
                if (first_in < 0) first_in = cyc;
                sent++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        sb_if.tvalid = 1'b0;
        checks++; if (recv != 100) begin errors++; $display("FAIL stream_count: got %0d want 100", recv); end
        checks++; if (last_out - first_out != 99) begin errors++; $display("FAIL stream_gapless: got span %0d want 99", last_out - first_out); end
        checks++; if (first_out - first_in != 3) begin errors++; $display("FAIL stream_latency: got %0d want 3", first_out - first_in); end
        checks++; if (b_pkt_cnt !== 16'd10) begin errors++; $display("FAIL stream_pkt_cnt: got %0d want 10", b_pkt_cnt); end
        checks++; if (b_beat_cnt !== 16'd100) begin errors++; $display("FAIL stream_beat_cnt: got %0d want 100", b_beat_cnt); end
        checks++; if (occ_max != 3) begin errors++; $display("FAIL stream_occ_peak: got %0d want 3", occ_max); end
    endtask

    task automatic test_backpressure();
        int sent, recv, first, last;
        sent = 0; recv = 0; first = -1; last = -1;
        for (int c = 0; c < 8; c++) begin
            step_a(1'b1, DW'(16'h0010 + sent), 1'b0, 4'h0, 1'b0);
            if (a_in_acc) sent++;
        end
        checks++; if (sent != 4) begin errors++; $display("FAIL fill_accepted: got %0d want 4", sent); end
        checks++; if (a_s_tready !== 1'b0) begin errors++; $display("FAIL fill_tready: got %b want 0", a_s_tready); end
        checks++; if (a_occ !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d want 4", a_occ); end
        checks++; if (a_prot_err !== 1'b0) begin errors++; $display("FAIL clean_stall_perr: got %b want 0", a_prot_err); end
        for (int c = 0; c < 12; c++) begin
            step_a(sent < 5, DW'(16'h0010 + sent), 1'b0, 4'h0, 1'b1);
            if (a_out_acc) begin
                checks++;
                if (a_out_pay[DW-1:0] !== DW'(16'h0010 + recv)) begin
                    errors++; $display("FAIL drain_beat%0d: got %h want %h", recv, a_out_pay[DW-1:0], DW'(16'h0010 + recv));
                end
                if (first < 0) first = c;
                last = c;
                recv++;
            end
            if (a_in_acc) sent++;
        end
        exp_beat_a += 5;
        checks++; if (recv != 5) begin errors++; $display("FAIL drain_count: got %0d want 5", recv); end
        checks++; if (last - first != 4) begin errors++; $display("FAIL drain_rate: got span %0d want 4", last - first); end
        checks++; if (a_beat_cnt !== CW'(exp_beat_a)) begin errors++; $display("FAIL drain_beat_cnt: got %0d want %0d", a_beat_cnt, exp_beat_a); end
        checks++; if (a_occ !== 3'd0) begin errors++; $display("FAIL drain_occ: got %0d want 0", a_occ); end
    endtask

    task automatic test_random();
        logic [PW-1:0] q[$];
        logic [PW-1:0] cur, got;
        int sent, recv, occ_exp, lasts;
        logic rdy;
        sent = 0; recv = 0; occ_exp = 0; lasts = 0; rdy = 1'b0;
        cur = PW'($urandom());
        for (int c = 0; c < 4000 && recv < 500; c++) begin
            rdy = ~rdy;
            step_a(sent < 500, cur[DW-1:0], cur[DW], cur[PW-1:DW+1], rdy);
            checks++;
            if (int'(a_occ_s) != occ_exp) begin
                errors++; $display("FAIL rand_occ cyc%0d: got %0d want %0d", c, a_occ_s, occ_exp);
            end
            if (a_out_acc) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra: got %h want no beat", a_out_pay);
                end else begin
                    got = q.pop_front();
                    if (a_out_pay !== got) begin
                        errors++; $display("FAIL rand_beat%0d: got %h want %h", recv, a_out_pay, got);
                    end
                end
                recv++;
            end
            if (a_in_acc) begin
                q.push_back(cur);
                if (cur[DW]) lasts++;
                cur = PW'($urandom());
                sent++;
            end
            occ_exp += int'(a_in_acc) - int'(a_out_acc);
        end
        exp_beat_a += 500;
        exp_pkt_a  += lasts;
        checks++; if (recv != 500) begin errors++; $display("FAIL rand_count: got %0d want 500", recv); end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d want 0", q.size()); end
        checks++; if (a_beat_cnt !== CW'(exp_beat_a)) begin errors++; $display("FAIL rand_beat_cnt: got %0d want %0d", a_beat_cnt, exp_beat_a); end
        checks++; if (a_pkt_cnt !== CW'(exp_pkt_a)) begin errors++; $display("FAIL rand_pkt_cnt: got %0d want %0d", a_pkt_cnt, exp_pkt_a); end
        checks++; if (a_prot_err !== 1'b0) begin errors++; $display("FAIL rand_perr: got %b want 0", a_prot_err); end
    endtask

    task automatic test_protocol();
        int sent;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            step_a(1'b1, 16'h0001, 1'b0, 4'h0, 1'b0);
            if (a_in_acc) sent++;
        end
        checks++; if (sent != 4 || a_prot_err !== 1'b0) begin
            errors++; $display("FAIL prot_pre: got sent=%0d perr=%b want 4 0", sent, a_prot_err);
        end
        step_a(1'b1, 16'h0002, 1'b0, 4'h0, 1'b0);
        checks++; if (a_prot_err !== 1'b1) begin errors++; $display("FAIL prot_detect: got %b want 1", a_prot_err); end
        repeat (3) step_a(1'b1, 16'h0002, 1'b0, 4'h0, 1'b0);
        checks++; if (a_prot_err !== 1'b1) begin errors++; $display("FAIL prot_sticky: got %b want 1", a_prot_err); end
    endtask

    task automatic test_reset_mid();
        int sent, recv;
        sa_if.tvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (a_prot_err !== 1'b0) begin errors++; $display("FAIL prot_clear: got %b want 0", a_prot_err); end
        rst_n = 1'b1;
        step_a(1'b1, 16'h00C0, 1'b1, 4'h0, 1'b1);
        step_a(1'b1, 16'h00C1, 1'b0, 4'h0, 1'b1);
        step_a(1'b1, 16'h00C2, 1'b0, 4'h0, 1'b1);
        step_a(1'b1, 16'h00C3, 1'b0, 4'h0, 1'b0);
        sa_if.tvalid = 1'b0;
        checks++;
        if (a_occ !== 3'd3 || a_beat_cnt !== 16'd1 || a_pkt_cnt !== 16'd1 || ma_if.tvalid !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got occ=%0d beat=%0d pkt=%0d v=%b want 3 1 1 1",
                               a_occ, a_beat_cnt, a_pkt_cnt, ma_if.tvalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ma_if.tvalid !== 1'b0 || a_occ !== 3'd0 || a_beat_cnt !== 16'd0 || a_pkt_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_reset: got v=%b occ=%0d beat=%0d pkt=%0d want all 0",
                               ma_if.tvalid, a_occ, a_beat_cnt, a_pkt_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sent = 0; recv = 0;
        for (int c = 0; c < 8; c++) begin
            step_a(sent < 2, DW'(16'h00D0 + sent), sent == 1, 4'h0, 1'b1);
            if (a_out_acc) begin
                checks++;
                if (a_out_pay[DW-1:0] !== DW'(16'h00D0 + recv) || a_out_pay[DW] !== (recv == 1)) begin
                    errors++; $display("FAIL post_mid_beat%0d: got d=%h l=%b want d=%h l=%b",
                                       recv, a_out_pay[DW-1:0], a_out_pay[DW], DW'(16'h00D0 + recv), (recv == 1));
                end
                recv++;
            end
            if (a_in_acc) sent++;
        end
        checks++;
        if (recv != 2 || a_pkt_cnt !== 16'd1 || a_beat_cnt !== 16'd2) begin
            errors++; $display("FAIL post_mid_counts: got recv=%0d pkt=%0d beat=%0d want 2 1 2", recv, a_pkt_cnt, a_beat_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        sa_if.tvalid = 1'b0; sa_if.tdata = '0; sa_if.tlast = 1'b0; sa_if.tuser = '0;
        sb_if.tvalid = 1'b0; sb_if.tdata = '0; sb_if.tlast = 1'b0; sb_if.tuser = '0;
        a_m_tready = 1'b1;
        b_m_tready = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_protocol();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
